// File: rtl/grad_dir_pkg.sv
// Shared types and helpers for the Canny gradient-direction quantiser.
package grad_dir_pkg;

  typedef enum logic [1:0] {
    DIR_0   = 2'b00,
    DIR_90  = 2'b01,
    DIR_45  = 2'b10,
    DIR_135 = 2'b11
  } dir_t;

  localparam int GRAD_W_DEF    = 11;
  localparam int LUT_MAX_DEF   = 9;
  localparam int SHIFT_MAX_DEF = 8;
  localparam int MAG_W         = 16;

  // Smallest shift in 0..shift_max that brings m into the LUT index range.
  function automatic logic [3:0] shift_sel(input logic [MAG_W-1:0] m,
                                           input int lut_max,
                                           input int shift_max);
    logic [3:0] s;
    s = 4'(shift_max);
    for (int i = 15; i >= 0; i--) begin
      if (i <= shift_max && 32'(m >> i) <= lut_max) s = 4'(i);
    end
    return s;
  endfunction

endpackage

// File: rtl/dir_quad_lut.sv
// 10x10 first-quadrant direction table (x = |gx| index, y = |gy| index), registered output.
module dir_quad_lut
  import grad_dir_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_en,
  input  logic [3:0] i_x,
  input  logic [3:0] i_y,
  output dir_t       o_dir
);

  // Bin edges at tan(22.5) ~ 0.414 and tan(67.5) ~ 2.414, scaled by 1000.
  function automatic dir_t quad(input logic [3:0] x, input logic [3:0] y);
    logic [15:0] ys, xh, xv;
    ys = 16'(y) * 16'd1000;
    xh = 16'(x) * 16'd414;
    xv = 16'(x) * 16'd2414;
    if (x == 4'd0 && y == 4'd0) return DIR_0;
    if (ys < xh)                return DIR_0;
    if (ys > xv)                return DIR_90;
    return DIR_45;
  endfunction

  dir_t dir_d, dir_q;

  always_comb begin
    dir_d = dir_q;
    if (i_en) dir_d = quad(i_x, i_y);
  end

  always_ff @(posedge i_clk) dir_q <= dir_d;

  assign o_dir = dir_q;

endmodule

// File: rtl/grad_dir_ctrl.sv
// Canny direction quantiser: abs/sign, shift-normalise, LUT, unfold; 4-cycle stallable pipe.
// Optional per-frame direction counters when GRAD_DIR_STATS_EN is defined.
module grad_dir_ctrl
  import grad_dir_pkg::*;
#(
  parameter int GRAD_W    = GRAD_W_DEF,
  parameter int LUT_MAX   = LUT_MAX_DEF,
  parameter int SHIFT_MAX = SHIFT_MAX_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [GRAD_W-1:0] i_gx,
  input  logic [GRAD_W-1:0] i_gy,
  input  logic              i_sof,
  input  logic              i_eol,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [1:0]        o_dir,
  output logic              o_sof,
  output logic              o_eol
`ifdef GRAD_DIR_STATS_EN
  ,
  output logic [19:0]       o_cnt0,
  output logic [19:0]       o_cnt45,
  output logic [19:0]       o_cnt90,
  output logic [19:0]       o_cnt135
`endif
);

  localparam logic [GRAD_W-1:0] LUT_MAX_G = GRAD_W'(LUT_MAX);

  logic adv;
  logic vld_p1_d, vld_p1_q, vld_p2_d, vld_p2_q, vld_p3_d, vld_p3_q;
  logic o_valid_d, o_valid_q, o_sof_d, o_sof_q, o_eol_d, o_eol_q;
  dir_t o_dir_d, o_dir_q, q_p3;

  logic signed [GRAD_W-1:0] gx_s, gy_s;
  logic [GRAD_W-1:0] ax_d, ay_d, ax_p1_q, ay_p1_q;
  logic neg_d, neg_p1_q, sof_p1_q, eol_p1_q;

  logic [GRAD_W-1:0] m, ix_full, iy_full;
  logic [3:0] shift, ix_d, iy_d, ix_p2_q, iy_p2_q;
  logic neg_p2_q, sof_p2_q, eol_p2_q;
  logic neg_p3_q, sof_p3_q, eol_p3_q;

  // A whole-pipe enable: any stall freezes every stage together.
  assign adv     = !o_valid_q || i_ready;
  assign o_ready = adv;

  always_comb begin
    gx_s     = i_gx;
    gy_s     = i_gy;
    ax_d     = (gx_s < 0) ? -gx_s : gx_s;
    ay_d     = (gy_s < 0) ? -gy_s : gy_s;
    neg_d    = gx_s[GRAD_W-1] ^ gy_s[GRAD_W-1];
    m        = (ax_p1_q >= ay_p1_q) ? ax_p1_q : ay_p1_q;
    shift    = shift_sel(MAG_W'(m), LUT_MAX, SHIFT_MAX);
    ix_full  = ax_p1_q >> shift;
    iy_full  = ay_p1_q >> shift;
    ix_d     = 4'(ix_full);
    iy_d     = 4'(iy_full);
    o_dir_d  = o_dir_q;
    if (adv) o_dir_d = (q_p3 == DIR_45 && neg_p3_q) ? DIR_135 : q_p3;
    vld_p1_d  = adv ? i_valid  : vld_p1_q;
    vld_p2_d  = adv ? vld_p1_q : vld_p2_q;
    vld_p3_d  = adv ? vld_p2_q : vld_p3_q;
    o_valid_d = adv ? vld_p3_q : o_valid_q;
    o_sof_d   = adv ? sof_p3_q : o_sof_q;
    o_eol_d   = adv ? eol_p3_q : o_eol_q;
  end

  // Stage 1: magnitude and sign capture
  always_ff @(posedge i_clk) begin
    if (adv) begin
      ax_p1_q  <= ax_d;
      ay_p1_q  <= ay_d;
      neg_p1_q <= neg_d;
      sof_p1_q <= i_sof;
      eol_p1_q <= i_eol;
      // Stage 2: normalised LUT indices
      ix_p2_q  <= ix_d;
      iy_p2_q  <= iy_d;
      neg_p2_q <= neg_p1_q;
      sof_p2_q <= sof_p1_q;
      eol_p2_q <= eol_p1_q;
      // Stage 3: sideband alongside the registered LUT output
      neg_p3_q <= neg_p2_q;
      sof_p3_q <= sof_p2_q;
      eol_p3_q <= eol_p2_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (adv && vld_p1_q) assert (ix_full <= LUT_MAX_G && iy_full <= LUT_MAX_G);
  end

  dir_quad_lut u_lut (
    .i_clk (i_clk),
    .i_en  (adv),
    .i_x   (ix_p2_q),
    .i_y   (iy_p2_q),
    .o_dir (q_p3)
  );

  // Stage 4: unfolded direction and output registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      vld_p1_q  <= 1'b0;
      vld_p2_q  <= 1'b0;
      vld_p3_q  <= 1'b0;
      o_valid_q <= 1'b0;
      o_dir_q   <= DIR_0;
      o_sof_q   <= 1'b0;
      o_eol_q   <= 1'b0;
    end else begin
      vld_p1_q  <= vld_p1_d;
      vld_p2_q  <= vld_p2_d;
      vld_p3_q  <= vld_p3_d;
      o_valid_q <= o_valid_d;
      o_dir_q   <= o_dir_d;
      o_sof_q   <= o_sof_d;
      o_eol_q   <= o_eol_d;
    end
  end

  assign o_valid = o_valid_q;
  assign o_dir   = o_dir_q;
  assign o_sof   = o_sof_q;
  assign o_eol   = o_eol_q;

`ifdef GRAD_DIR_STATS_EN
  // Counters indexed by the dir_t encoding; an SOF transfer restarts the frame.
  logic [19:0] cnt_d [4];
  logic [19:0] cnt_q [4];

  always_comb begin
    for (int k = 0; k < 4; k++) cnt_d[k] = cnt_q[k];
    if (o_valid_q && i_ready) begin
      if (o_sof_q) for (int k = 0; k < 4; k++) cnt_d[k] = '0;
      if (cnt_d[o_dir_q] != '1) cnt_d[o_dir_q] = cnt_d[o_dir_q] + 20'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < 4; k++) cnt_q[k] <= '0;
    end else begin
      for (int k = 0; k < 4; k++) cnt_q[k] <= cnt_d[k];
    end
  end

  assign o_cnt0   = cnt_q[DIR_0];
  assign o_cnt45  = cnt_q[DIR_45];
  assign o_cnt90  = cnt_q[DIR_90];
  assign o_cnt135 = cnt_q[DIR_135];
`endif

endmodule

// File: tb/tb_grad_dir_ctrl.sv
// Directed bench for grad_dir_ctrl: latency, direction bins, stall, reset, optional stats.
module tb_grad_dir_ctrl;
  import grad_dir_pkg::*;

  localparam int GW = 11;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic i_valid = 1'b0, i_sof = 1'b0, i_eol = 1'b0, i_ready = 1'b1;
  logic [GW-1:0] gx = '0, gy = '0;
  logic o_ready, o_valid, o_sof, o_eol;
  logic [1:0] o_dir;
`ifdef GRAD_DIR_STATS_EN
  logic [19:0] c0, c45, c90, c135;
`endif

  int n_chk = 0;
  int n_pass = 0;

  int         sx [8] = '{5, -300, 300, 0, -1024, 7, 0, -4};
  int         sy [8] = '{0, 300, 300, -1020, 0, -7, 3, -4};
  logic [1:0] sd [8] = '{2'b00, 2'b11, 2'b10, 2'b01, 2'b00, 2'b11, 2'b01, 2'b10};

  always #5 clk = ~clk;

  grad_dir_ctrl dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_gx    (gx),
    .i_gy    (gy),
    .i_sof   (i_sof),
    .i_eol   (i_eol),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_dir   (o_dir),
    .o_sof   (o_sof),
    .o_eol   (o_eol)
`ifdef GRAD_DIR_STATS_EN
    ,
    .o_cnt0   (c0),
    .o_cnt45  (c45),
    .o_cnt90  (c90),
    .o_cnt135 (c135)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_one(input int x, input int y, input logic sof, input logic eol,
                          input logic [1:0] d, input string tag);
    gx = GW'(x); gy = GW'(y); i_sof = sof; i_eol = eol; i_valid = 1'b1;
    #1 chk({tag, "_rdy"}, 32'(o_ready), 32'd1);
    step();
    i_valid = 1'b0; i_sof = 1'b0; i_eol = 1'b0;
    step();
    step();
    chk({tag, "_early"}, 32'(o_valid), 32'd0);
    step();
    chk({tag, "_vld"}, 32'(o_valid), 32'd1);
    chk({tag, "_dir"}, 32'(o_dir), 32'(d));
    chk({tag, "_sof"}, 32'(o_sof), 32'(sof));
    chk({tag, "_eol"}, 32'(o_eol), 32'(eol));
    step();
  endtask

  initial begin
    int idx, head;
    logic exp_vld, exp_rdy;

    #1 rst = 1'b1;
    #1;
    chk("rst_vld", 32'(o_valid), 32'd0);
    chk("rst_dir", 32'(o_dir), 32'd0);
    chk("rst_sof", 32'(o_sof), 32'd0);
    chk("rst_eol", 32'(o_eol), 32'd0);
    step();
    step();
    rst = 1'b0;
    #1 chk("rst_rdy", 32'(o_ready), 32'd1);

    send_one(5, 0, 1'b1, 1'b0, 2'b00, "h5");
    send_one(-300, 300, 1'b0, 1'b1, 2'b11, "d135");
    send_one(300, 300, 1'b0, 1'b0, 2'b10, "d45");
    send_one(0, -1020, 1'b0, 1'b0, 2'b01, "v1020");
    send_one(-1024, 0, 1'b0, 1'b0, 2'b00, "h1024");
    send_one(0, 0, 1'b0, 1'b0, 2'b00, "zero");
    send_one(100, -40, 1'b0, 1'b0, 2'b00, "h100");

    // Back-to-back stream with i_ready low in cycles 5..7.
    idx = 0;
    head = 0;
    for (int c = 0; c < 17; c++) begin
      i_ready = !(c >= 5 && c <= 7);
      i_valid = (idx < 8);
      if (idx < 8) begin
        gx = GW'(sx[idx]); gy = GW'(sy[idx]);
        i_sof = (idx == 0); i_eol = (idx == 7);
      end else begin
        i_sof = 1'b0; i_eol = 1'b0;
      end
      #1;
      exp_vld = (c >= 4 && c <= 14);
      exp_rdy = !(exp_vld && !i_ready);
      chk("strm_rdy", 32'(o_ready), 32'(exp_rdy));
      chk("strm_vld", 32'(o_valid), 32'(exp_vld));
      if (exp_vld) begin
        chk("strm_dir", 32'(o_dir), 32'(sd[head]));
        chk("strm_sof", 32'(o_sof), 32'(head == 0));
        chk("strm_eol", 32'(o_eol), 32'(head == 7));
        if (i_ready) head++;
      end
      if (i_valid && exp_rdy) idx++;
      step();
    end
    i_valid = 1'b0; i_ready = 1'b1; i_sof = 1'b0; i_eol = 1'b0;

    // Reset with one sample at the output and three in flight.
    for (int c = 0; c < 4; c++) begin
      gx = GW'(-300); gy = GW'(300); i_valid = 1'b1;
      step();
    end
    i_valid = 1'b0;
    #1;
    chk("mid_pre_vld", 32'(o_valid), 32'd1);
    chk("mid_pre_dir", 32'(o_dir), 32'd3);
    rst = 1'b1;
    #1;
    chk("mid_rst_vld", 32'(o_valid), 32'd0);
    chk("mid_rst_dir", 32'(o_dir), 32'd0);
    step();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      chk("mid_stale", 32'(o_valid), 32'd0);
    end
    send_one(300, 300, 1'b0, 1'b1, 2'b10, "post_rst");

`ifdef GRAD_DIR_STATS_EN
    send_one(300, 300, 1'b1, 1'b0, 2'b10, "st_a");
    send_one(4, 4, 1'b0, 1'b0, 2'b10, "st_b");
    send_one(0, -1020, 1'b0, 1'b0, 2'b01, "st_c");
    send_one(-300, 300, 1'b0, 1'b1, 2'b11, "st_d");
    chk("cnt0", 32'(c0), 32'd0);
    chk("cnt45", 32'(c45), 32'd2);
    chk("cnt90", 32'(c90), 32'd1);
    chk("cnt135", 32'(c135), 32'd1);
    send_one(5, 0, 1'b1, 1'b0, 2'b00, "st_e");
    chk("cnt0_new", 32'(c0), 32'd1);
    chk("cnt45_new", 32'(c45), 32'd0);
    chk("cnt90_new", 32'(c90), 32'd0);
    chk("cnt135_new", 32'(c135), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/grad_dir_ctrl.md
Name: grad_dir_ctrl

Overview:
- Streaming controller for the Canny direction-quantisation stage. Sits between the Sobel gradient stage and non-maximum suppression.
- Accepts signed gx/gy pairs on a valid/ready handshake, takes absolute values and records the signs.
- Normalises both magnitudes with a shared right shift into the 0..9 LUT index range, then sequences a registered first-quadrant direction LUT.
- Unfolds the LUT result into one of four directions (0°, 45°, 90°, 135°). Stalls the whole pipeline on downstream backpressure and carries SOF/EOL sideband through.

Parameters:
- GRAD_W, 11, signed gradient width (Sobel range ±1020; -1024 legal)
- LUT_MAX, 9, largest LUT index per axis (LUT is 10x10)
- SHIFT_MAX, 8, largest normalisation shift (GRAD_W-3)

Ports:
- i_clk  in  1  clock, all logic on rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_valid  in  1  input sample valid
- o_ready  out  1  controller can accept a sample
- i_gx  in  GRAD_W  signed horizontal gradient
- i_gy  in  GRAD_W  signed vertical gradient
- i_sof  in  1  first pixel of frame (sideband)
- i_eol  in  1  last pixel of line (sideband)
- o_valid  out  1  output direction valid
- i_ready  in  1  downstream accepts
- o_dir  out  2  00=0°, 10=45°, 01=90°, 11=135°
- o_sof  out  1  sideband aligned with o_dir
- o_eol  out  1  sideband aligned with o_dir

Behaviour:
- Reset: all stage valids, o_valid, o_dir, o_sof and o_eol are 0 immediately and asynchronously. o_ready is 1 once reset deasserts. Reset mid-stream discards all in-flight samples.
- Global advance enable: adv = !o_valid | i_ready. o_ready = adv. A transfer happens when i_valid & o_ready. Valid bubbles do not compress.
- S1 (on adv):
  - register ax = |gx|, ay = |gy| as GRAD_W-bit unsigned (-1024 → 1024, no saturation)
  - register neg = sign(gx) XOR sign(gy); a zero gradient counts as positive
  - register valid, sof and eol
- S2: m = max(ax, ay).
  - s = smallest value in 0..SHIFT_MAX with (m >> s) ≤ LUT_MAX.
  - Register ix = ax >> s and iy = ay >> s, each 4 bits.
  - Both are guaranteed ≤ LUT_MAX; a non-compliant value is an assertion failure.
- S3: sub-module lookup q = LUT[ix][iy], registered, qualified by the enable adv.
  - ix indexes |gx| and iy indexes |gy|.
  - q: 00 = near-horizontal, 01 = near-vertical, 10 = diagonal.
  - Entry [0][0] = 00.
- S4: o_dir = (q == 10 && neg) ? 11 : q. Register o_valid, o_sof and o_eol.
- Latency: exactly 4 cycles from accepted input to o_valid with no stall. Throughput is 1 sample per cycle.
- Stall (o_valid & !i_ready): every stage, including the LUT output register, holds. o_dir, o_sof and o_eol stay stable and no sample is dropped or duplicated.
- Simultaneous input accept and output accept in the same cycle is legal.
- Integer truncation of the shift is intended. Direction error near bin edges is accepted.

Optional Feature:
- Macro GRAD_DIR_STATS_EN.
- Defined:
  - adds outputs o_cnt0, o_cnt45, o_cnt90, o_cnt135, each 20-bit, counting directions transferred out (o_valid & i_ready)
  - counters saturate at max
  - counters are cleared when a sample with o_sof=1 transfers; that sample counts as the first of the new frame
  - counters reset to 0
- Undefined: ports and logic absent; core behaviour identical.

Decomposition:
- Package grad_dir_pkg holds:
  - typedef dir_t, 2-bit enum: DIR_0=00, DIR_90=01, DIR_45=10, DIR_135=11
  - constants GRAD_W_DEF, LUT_MAX_DEF, SHIFT_MAX_DEF
  - function for the shift select
- Sub-module dir_quad_lut holds the 10x10 first-quadrant table with a registered output and an i_en input (i_clk, i_en, 4-bit x, 4-bit y, dir_t out).
- Top holds the handshake, abs/sign, normalisation, unfold and sideband.

Test Plan:
- gx=5, gy=0, i_ready=1 → 4 cycles later o_valid=1, o_dir=00.
- gx=-300, gy=300 → s=5, index (9,9), q=10, neg=1 → o_dir=11; gx=300, gy=300 → o_dir=10.
- gx=0, gy=-1020 → s=7, index (0,7) → o_dir=01; gx=-1024, gy=0 → s=7, index (8,0) → o_dir=00.
- Stream 8 samples back-to-back with i_ready low for 3 cycles mid-stream → all 8 outputs arrive in order, outputs stable while stalled, o_ready low only while o_valid & !i_ready.
- Assert i_rst for 1 cycle with 3 samples in flight → o_valid=0 at once, no stale output afterwards, next sample still has 4-cycle latency.
- With GRAD_DIR_STATS_EN defined: frame of 2×45°, 1×90°, 1×135° with SOF on the first sample → counters read 0/2/1/1 (o_cnt0/o_cnt45/o_cnt90/o_cnt135). The next SOF sample restarts the counts with itself as the first.
